// File: rtl/jg3_gen_if.sv
// jg3_gen_if: request/handshake/status bundle between a consumer and jg3_gen.
interface jg3_gen_if;
    logic       start;
    logic       abort;
    logic [1:0] XY;
    logic       ready;
    logic [2:0] ABC;
    logic       valid;
    logic       last;
    logic       busy;
    logic       done;
    logic [2:0] count;
    modport master (output start, abort, XY, ready, input ABC, valid, last, busy, done, count);
    modport slave  (input start, abort, XY, ready, output ABC, valid, last, busy, done, count);
endinterface

// File: rtl/jg3_gen.sv
// jg3_gen: enumerates every 3-bit code whose decode matches a latched {X,Y} target,
// handing each off over a valid/ready handshake in ascending or descending order.
module jg3_gen #(
    parameter logic DIR = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    jg3_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
    localparam logic [2:0] FIRST = DIR ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST  = DIR ? 3'd0 : 3'd7;
    state_t     state_q;
    logic [2:0] cand_q, abc_q, count_q, hcnt_q;
    logic [1:0] tgt_q;
    logic       valid_q, last_q, done_q;
    logic [2:0] cand_d, hcnt_d;
    logic       hit, at_end, more;
    function automatic logic [1:0] dec(input logic [2:0] c);
        return {c >= 3'd5, (c == 3'd0) || (c == 3'd7)};
    endfunction
    assign cand_d = DIR ? cand_q - 3'd1 : cand_q + 3'd1;
    assign hcnt_d = hcnt_q + 3'd1;
    assign hit    = dec(cand_q) == tgt_q;
    assign at_end = cand_q == LAST;
    // Any later code in scan order that still matches the target
    always_comb begin
        more = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((DIR ? 3'(i) < cand_q : 3'(i) > cand_q) && dec(3'(i)) == tgt_q) more = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= 3'd0;
            abc_q   <= 3'd0;
            count_q <= 3'd0;
            hcnt_q  <= 3'd0;
            tgt_q   <= 2'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start && !bus.abort) begin
                    tgt_q   <= bus.XY;
                    cand_q  <= FIRST;
                    hcnt_q  <= 3'd0;
                    state_q <= SCAN;
                end
                SCAN: if (bus.abort) begin
                    state_q <= IDLE;
                end else if (hit) begin
                    abc_q   <= cand_q;
                    valid_q <= 1'b1;
                    last_q  <= !more;
                    state_q <= EMIT;
                end else if (at_end) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    cand_q  <= cand_d;
                end
                EMIT: if (bus.abort) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    state_q <= IDLE;
                end else if (bus.ready) begin
                    hcnt_q  <= hcnt_d;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= at_end;
                    cand_q  <= at_end ? cand_q : cand_d;
                    state_q <= at_end ? DONE : SCAN;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    count_q <= bus.abort ? count_q : hcnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.ABC   = abc_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;
    assign bus.busy  = state_q != IDLE;
    assign bus.done  = done_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_jg3_gen.sv
// tb_jg3_gen: scoreboard bench driving ascending and descending jg3_gen instances in lockstep.
module tb_jg3_gen;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [1:0] XY = 2'd0;
    int total = 0, bad = 0;
    bit sel = 1'b0;
    logic [3:0] sb[$];
    jg3_gen_if b0();
    jg3_gen_if b1();
    jg3_gen #(.DIR(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    jg3_gen #(.DIR(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    assign b0.start = start; assign b0.abort = abort; assign b0.XY = XY; assign b0.ready = ready;
    assign b1.start = start; assign b1.abort = abort; assign b1.XY = XY; assign b1.ready = ready;
    wire       s_valid = sel ? b1.valid : b0.valid;
    wire       s_last  = sel ? b1.last  : b0.last;
    wire       s_done  = sel ? b1.done  : b0.done;
    wire       s_busy  = sel ? b1.busy  : b0.busy;
    wire [2:0] s_abc   = sel ? b1.ABC   : b0.ABC;
    wire [2:0] s_count = sel ? b1.count : b0.count;
    always #5 clk = ~clk;

    function automatic logic [7:0] match_set(input logic [1:0] xy);
        return xy == 2'b01 ? 8'h01 : xy == 2'b00 ? 8'h1E : xy == 2'b10 ? 8'h60 : 8'h80;
    endfunction

    task automatic wait_idle();
        int i;
        ready = 1'b1;
        for (i = 0; i < 30 && (b0.busy || b1.busy); i++) @(negedge clk);
        if (b0.busy || b1.busy) begin
            total++; bad++;
            $display("FAIL idle_timeout busy0=%0b busy1=%0b required 0", b0.busy, b1.busy);
        end
    endtask

    task automatic run_enum(input bit s, input logic [1:0] xy, input int stall);
        logic [7:0] m;
        logic [2:0] c;
        logic [3:0] e;
        int n, k, cyc, first, prev, sc;
        bit fin;
        m = match_set(xy); n = 0; k = -1; sb.delete();
        for (int i = 0; i < 8; i++) begin
            c = s ? 3'(7 - i) : 3'(i);
            if (m[c]) begin
                if (k < 0) k = i;
                sb.push_back({c, 1'b0});
                n++;
            end
        end
        e = sb.pop_back(); e[0] = 1'b1; sb.push_back(e);
        wait_idle();
        sel = s;
        @(negedge clk); XY = xy; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; first = 0; prev = 0; sc = 0; fin = 1'b0;
        while (!fin && cyc < 40) begin
            if (s_valid) begin
                if (first == 0) begin
                    first = cyc; total++;
                    if (first !== k + 2) begin bad++; $display("FAIL first_latency dir=%0b xy=%b got=%0d want=%0d", s, xy, first, k + 2); end
                end
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL extra_code dir=%0b xy=%b abc=%b want none", s, xy, s_abc); end
                else if ({s_abc, s_last} !== sb[0]) begin bad++; $display("FAIL code dir=%0b xy=%b abc/last=%b/%b want=%b/%b", s, xy, s_abc, s_last, sb[0][3:1], sb[0][0]); end
                if (sc < stall) begin ready = 1'b0; sc++; end
                else begin
                    ready = 1'b1;
                    if (stall == 0 && prev != 0) begin
                        total++;
                        if (cyc - prev !== 2) begin bad++; $display("FAIL rate dir=%0b xy=%b gap=%0d want=2", s, xy, cyc - prev); end
                    end
                    prev = cyc;
                    if (sb.size() != 0) void'(sb.pop_front());
                end
            end else ready = 1'b1;
            if (s_done) begin
                fin = 1'b1; total++;
                if (sb.size() != 0) begin bad++; $display("FAIL early_done dir=%0b xy=%b left=%0d want 0", s, xy, sb.size()); end
            end
            @(negedge clk); cyc++;
        end
        total++;
        if (!fin) begin bad++; $display("FAIL done_timeout dir=%0b xy=%b cycles=%0d", s, xy, cyc); end
        else if ({s_done, s_busy, s_count} !== {1'b0, 1'b0, 3'(n)}) begin
            bad++; $display("FAIL post_done dir=%0b xy=%b done/busy/count=%b/%b/%0d want 0/0/%0d", s, xy, s_done, s_busy, s_count, n);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({b0.ABC, b0.valid, b0.last, b0.busy, b0.done, b0.count, b1.ABC, b1.valid, b1.busy, b1.done, b1.count} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b/%b want all 0", {b0.ABC, b0.valid, b0.busy, b0.done, b0.count}, {b1.ABC, b1.valid, b1.busy, b1.done, b1.count});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_enum();
        run_enum(1'b0, 2'b01, 0);
        run_enum(1'b0, 2'b00, 0);
        run_enum(1'b0, 2'b10, 5);
        run_enum(1'b1, 2'b00, 0);
        run_enum(1'b0, 2'b11, 0);
        run_enum(1'b1, 2'b10, 0);
        run_enum(1'b1, 2'b01, 3);
    endtask

    task automatic test_start_abort_idle();
        wait_idle();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        total++;
        if (b0.busy !== 1'b0) begin bad++; $display("FAIL start_abort_idle busy=%b want 0", b0.busy); end
    endtask

    task automatic test_abort();
        int nv;
        bit saw_done;
        run_enum(1'b0, 2'b01, 0);
        wait_idle();
        sel = 1'b0; nv = 0; saw_done = 1'b0;
        @(negedge clk); XY = 2'b00; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 30 && nv < 2; i++) begin
            if (b0.valid) nv++;
            if (nv < 2) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        total++;
        if ({b0.valid, b0.busy} !== 2'b00) begin bad++; $display("FAIL abort_emit valid/busy=%b/%b want 0/0", b0.valid, b0.busy); end
        for (int i = 0; i < 12; i++) begin
            if (b0.done) saw_done = 1'b1;
            @(negedge clk);
        end
        total++;
        if (saw_done || b0.count !== 3'd1) begin bad++; $display("FAIL abort_count done_seen=%b count=%0d want 0/1", saw_done, b0.count); end
    endtask

    task automatic test_async_reset();
        wait_idle();
        @(negedge clk); XY = 2'b00; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0; #1;
        total++;
        if ({b0.ABC, b0.valid, b0.last, b0.busy, b0.done, b0.count} !== '0) begin
            bad++; $display("FAIL async_reset got=%b want all 0", {b0.ABC, b0.valid, b0.last, b0.busy, b0.done, b0.count});
        end
        @(negedge clk); rst_n = 1'b1;
        run_enum(1'b0, 2'b00, 0);
    endtask

    initial begin
        test_reset();
        test_enum();
        test_start_abort_idle();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jg3_gen.md
JG3_GEN -- requirements
Module: jg3_gen

Interface
REQ-001 SHALL have parameter DIR, default 0; 0 = scan codes ascending (000 to 111), 1 = scan descending (111 to 000).
REQ-002 SHALL have port clk, input, 1 bit; the single clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit; requests enumeration, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit; synchronous cancel of the enumeration in progress.
REQ-006 SHALL have port XY, input, 2 bits; target pair, XY[1] = X and XY[0] = Y, latched when start is accepted.
REQ-007 SHALL have port ready, input, 1 bit; consumer accepts ABC.
REQ-008 SHALL have port ABC, output, 3 bits; emitted code that maps to the target pair.
REQ-009 SHALL have port valid, output, 1 bit; ABC is presented.
REQ-010 SHALL have port last, output, 1 bit; the current ABC is the final match in scan order.
REQ-011 SHALL have port busy, output, 1 bit; high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit; one-cycle completion pulse.
REQ-013 SHALL have port count, output, 3 bits; number of codes handed off in the last completed enumeration.

Function
REQ-014 SHALL use the decode function f(ABC) = {X,Y}, defined as: X = 1 when ABC >= 101; Y = 1 when ABC = 000 or ABC = 111.
REQ-015 SHALL therefore produce these match sets: XY=01 gives {000}; XY=00 gives {001,010,011,100}; XY=10 gives {101,110}; XY=11 gives {111}.
REQ-016 SHALL implement states IDLE, SCAN, EMIT and DONE, with registered outputs.
REQ-017 IDLE: when start=1 and abort=0, SHALL latch XY, load the internal candidate register cand with 000 (DIR=0) or 111 (DIR=1), clear the handoff counter, and enter SCAN.
REQ-018 SCAN: SHALL evaluate one candidate per cycle.
REQ-019 SCAN: when f(cand) equals the target, SHALL register ABC <= cand and valid <= 1, and enter EMIT.
REQ-020 SCAN: when f(cand) does not equal the target and cand is the end code (111 for DIR=0, 000 for DIR=1), SHALL enter DONE; otherwise it SHALL step cand by +1 (DIR=0) or -1 (DIR=1).
REQ-021 EMIT: SHALL hold ABC and valid stable until ready=1.
REQ-022 EMIT: on a handshake (valid & ready) SHALL increment the handoff counter and clear valid; it SHALL then enter DONE if cand is the end code, else step cand and return to SCAN.
REQ-023 last SHALL equal valid AND (no code strictly beyond cand in scan order maps to the target).
REQ-024 DONE: SHALL assert done for exactly one cycle, load count from the handoff counter, and return to IDLE.
REQ-025 count SHALL hold its value until the next DONE.
REQ-026 Latency: first valid SHALL rise k+1 cycles after the start-sampling edge, where k is the number of non-matching candidates scanned before the first match.
REQ-027 Latency: a ready held at 1 SHALL sustain one code per 2 cycles.
REQ-028 start while busy=1 SHALL be ignored, with no queuing.
REQ-029 abort in SCAN, EMIT or DONE SHALL return the block to IDLE at the next edge with valid=0 and done=0; count SHALL be unchanged.
REQ-030 abort with ready=1 in EMIT: abort SHALL win and the handshake SHALL NOT be counted.
REQ-031 start and abort together in IDLE: the block SHALL remain in IDLE.
REQ-032 cand SHALL never wrap; enumeration SHALL terminate after at most 8 candidates.
REQ-033 XY, when changed mid-operation, SHALL have no effect until the next accepted start.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, ABC=000, valid=0, last=0, busy=0, done=0, count=000, cand=000, and the latched target=00.
REQ-035 Reset asserted mid-enumeration SHALL discard all progress; no done pulse SHALL be generated.
REQ-036 After rst_n rises, the first edge SHALL be able to accept start.

Verification
REQ-037 DIR=0, XY=01, ready=1, start pulse -> ABC=000 with valid=1 and last=1 one cycle after start is sampled; then done=1 and count=001.
REQ-038 DIR=0, XY=00, ready=1 -> ABC sequence 001,010,011,100 with last only on 100; done=1, count=100.
REQ-039 DIR=0, XY=10, ready=0 for 5 cycles then 1 -> ABC=101 held stable with valid=1 for 5 cycles; then 110 with last=1; count=010.
REQ-040 DIR=1, XY=00, ready=1 -> ABC sequence 100,011,010,001 with last on 001; count=100.
REQ-041 XY=00, abort with ready=1 during the second EMIT -> valid=0 and busy=0 next cycle; done never pulses; count keeps its prior value.
REQ-042 rst_n driven low mid-SCAN between clock edges -> all outputs 0 before the next edge; start after release -> normal enumeration.
